// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings for the per-register hazard scoreboard.
package hazard_defs;

   // Forward-select encoding seen by the datapath muxes
   localparam logic [1:0] FWD_NONE = 2'd0;
   localparam logic [1:0] FWD_E    = 2'd1;
   localparam logic [1:0] FWD_M    = 2'd2;
   localparam logic [1:0] FWD_W    = 2'd3;

   // Producer stage held in a scoreboard entry; deliberately equal to the FWD_* codes
   localparam logic [1:0] STG_NONE = 2'd0;
   localparam logic [1:0] STG_E    = 2'd1;
   localparam logic [1:0] STG_M    = 2'd2;
   localparam logic [1:0] STG_W    = 2'd3;

   // HI/LO live above the GPRs as ordinary entries
   localparam int REG_HI = 32;
   localparam int REG_LO = 33;

   // A select captured in D points one stage further once the consumer is in E
   function automatic logic [1:0] fwd_shift(input logic [1:0] f);
      case (f)
         FWD_E:   return FWD_M;
         FWD_M:   return FWD_W;
         default: return FWD_NONE;
      endcase
   endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// One scoreboard entry: tracks the newest in-flight writer of a single register.
module sb_entry
   import hazard_defs::*;
#(
   parameter int LW = 3
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          adv_i,
   input  logic          alloc_i,
   input  logic [LW-1:0] lat_i,
   input  logic          varlat_i,
   input  logic          done_i,
   input  logic          flush_i,
   output logic          busy_o,
   output logic [1:0]    stg_o,
   output logic          rdy_early_o,
   output logic          rdy_late_o
);

   logic          busy_q, busy_d;
   logic [1:0]    stg_q, stg_d;
   logic [LW-1:0] cnt_q, cnt_d;
   logic          var_q, var_d;
   logic [LW-1:0] cnt_nxt;

   // Countdown as it will stand after this edge; early consumers look one cycle ahead
   assign cnt_nxt     = (adv_i && !var_q && cnt_q != '0) ? cnt_q - LW'(1) : cnt_q;
   assign rdy_early_o = ~var_q & (cnt_nxt == '0);
   assign rdy_late_o  = ~var_q & (cnt_q <= LW'(1));
   assign busy_o      = busy_q;
   assign stg_o       = stg_q;

   // Next-state: advance/retire, then done, then flush; a new allocation overrides all of them
   always_comb begin
      busy_d = busy_q;
      stg_d  = stg_q;
      cnt_d  = cnt_q;
      var_d  = var_q;
      if (adv_i && busy_q) begin
         if (stg_q != STG_W) begin
            stg_d = stg_q + 2'd1;
         end else if (!var_q) begin
            // a variable-latency result still outstanding keeps the entry parked in W
            busy_d = 1'b0;
            stg_d  = STG_NONE;
            cnt_d  = '0;
         end
         if (!var_q && cnt_q != '0) cnt_d = cnt_q - LW'(1);
      end
      if (done_i && var_q) begin
         var_d = 1'b0;
         cnt_d = '0;
      end
      if (flush_i && busy_q && stg_q != STG_W) begin
         busy_d = 1'b0;
         stg_d  = STG_NONE;
         cnt_d  = '0;
         var_d  = 1'b0;
      end
      if (alloc_i) begin
         busy_d = 1'b1;
         stg_d  = STG_E;
         cnt_d  = lat_i;
         var_d  = varlat_i;
      end
   end

   // Entry state registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         busy_q <= 1'b0;
         stg_q  <= STG_NONE;
         cnt_q  <= '0;
         var_q  <= 1'b0;
      end else begin
         busy_q <= busy_d;
         stg_q  <= stg_d;
         cnt_q  <= cnt_d;
         var_q  <= var_d;
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register hazard unit: stall/flush/forward control for the F/D/E stages.
module hazard_scoreboard
   import hazard_defs::*;
#(
   parameter int NREG = 34,
   parameter int AW   = 6,
   parameter int LW   = 3
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          d_valid,
   input  logic [AW-1:0] d_rs,
   input  logic [AW-1:0] d_rt,
   input  logic          d_rs_use,
   input  logic          d_rt_use,
   input  logic          d_early,
   input  logic          d_wen,
   input  logic [AW-1:0] d_wreg,
   input  logic [LW-1:0] d_lat,
   input  logic          d_varlat,
   input  logic          e_flush,
   input  logic          flush_all,
   input  logic          ex_busy,
   input  logic          done_valid,
   input  logic [AW-1:0] done_reg,
   output logic          stallF,
   output logic          stallD,
   output logic          stallE,
   output logic          flushE,
   output logic [1:0]    fwd_rs_d,
   output logic [1:0]    fwd_rt_d,
   output logic [1:0]    fwd_rs_e,
   output logic [1:0]    fwd_rt_e
);

   logic            adv, hz, alloc, d_moves;
   logic [NREG-1:0] busy_v, rdy_e_v, rdy_l_v;
   logic [1:0]      stg_v [NREG];
   logic            rs_busy, rs_rdy_e, rs_rdy_l, rt_busy, rt_rdy_e, rt_rdy_l;
   logic [1:0]      rs_stg, rt_stg;
   logic            rs_live, rt_live, rs_ok, rt_ok;
   logic [1:0]      fwd_rs_e_q, fwd_rs_e_d, fwd_rt_e_q, fwd_rt_e_d;

   assign adv     = ~ex_busy;
   assign d_moves = adv & d_valid & ~hz & ~e_flush & ~flush_all;
   assign alloc   = d_moves & d_wen & (d_wreg != '0);

   for (genvar r = 0; r < NREG; r++) begin : g_entry
      sb_entry #(.LW(LW)) u_entry (
         .clk         (clk),
         .resetn      (resetn),
         .adv_i       (adv),
         .alloc_i     (alloc && d_wreg == AW'(r)),
         .lat_i       (d_lat),
         .varlat_i    (d_varlat),
         .done_i      (done_valid && done_reg == AW'(r)),
         .flush_i     (flush_all),
         .busy_o      (busy_v[r]),
         .stg_o       (stg_v[r]),
         .rdy_early_o (rdy_e_v[r]),
         .rdy_late_o  (rdy_l_v[r])
      );
   end

   // Source lookup; indices at or beyond NREG read as untracked
   always_comb begin
      rs_busy = 1'b0; rs_stg = STG_NONE; rs_rdy_e = 1'b0; rs_rdy_l = 1'b0;
      rt_busy = 1'b0; rt_stg = STG_NONE; rt_rdy_e = 1'b0; rt_rdy_l = 1'b0;
      for (int r = 0; r < NREG; r++) begin
         if (d_rs == AW'(r)) begin
            rs_busy = busy_v[r]; rs_stg = stg_v[r]; rs_rdy_e = rdy_e_v[r]; rs_rdy_l = rdy_l_v[r];
         end
         if (d_rt == AW'(r)) begin
            rt_busy = busy_v[r]; rt_stg = stg_v[r]; rt_rdy_e = rdy_e_v[r]; rt_rdy_l = rdy_l_v[r];
         end
      end
   end

   assign rs_live = d_rs_use & (d_rs != '0) & rs_busy;
   assign rt_live = d_rt_use & (d_rt != '0) & rt_busy;
   assign rs_ok   = d_early ? rs_rdy_e : rs_rdy_l;
   assign rt_ok   = d_early ? rt_rdy_e : rt_rdy_l;
   assign hz      = d_valid & ((rs_live & ~rs_ok) | (rt_live & ~rt_ok));

   // ex_busy is a raw input, so gate with reset to keep every output low while reset is held
   assign stallE   = resetn & ex_busy;
   assign stallD   = resetn & (hz | ex_busy);
   assign stallF   = stallD;
   assign flushE   = resetn & hz & ~ex_busy;
   assign fwd_rs_d = (rs_live & rs_ok) ? rs_stg : FWD_NONE;
   assign fwd_rt_d = (rt_live & rt_ok) ? rt_stg : FWD_NONE;

   // E-stage selects: follow the instruction into E, load a bubble otherwise, hold on stallE
   always_comb begin
      fwd_rs_e_d = fwd_rs_e_q;
      fwd_rt_e_d = fwd_rt_e_q;
      if (adv) begin
         fwd_rs_e_d = d_moves ? fwd_shift(fwd_rs_d) : FWD_NONE;
         fwd_rt_e_d = d_moves ? fwd_shift(fwd_rt_d) : FWD_NONE;
      end
   end

   // E-stage select registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         fwd_rs_e_q <= FWD_NONE;
         fwd_rt_e_q <= FWD_NONE;
      end else begin
         fwd_rs_e_q <= fwd_rs_e_d;
         fwd_rt_e_q <= fwd_rt_e_d;
      end
   end

   assign fwd_rs_e = fwd_rs_e_q;
   assign fwd_rt_e = fwd_rt_e_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with a queue of expected output vectors.
module tb_hazard_scoreboard;
   import hazard_defs::*;

   logic       clk = 1'b0;
   logic       resetn;
   logic       d_valid, d_rs_use, d_rt_use, d_early, d_wen, d_varlat;
   logic [5:0] d_rs, d_rt, d_wreg, done_reg;
   logic [2:0] d_lat;
   logic       e_flush, flush_all, ex_busy, done_valid;
   logic       stallF, stallD, stallE, flushE;
   logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

   typedef struct packed {
      logic       sf, sd, se, fe;
      logic [1:0] rsd, rtd, rse, rte;
   } exp_t;

   exp_t  exq[$];
   string tagq[$];
   int    errors = 0;
   int    checks = 0;

   always #5 clk = ~clk;

   hazard_scoreboard #(.NREG(34), .AW(6), .LW(3)) dut (
      .clk(clk), .resetn(resetn),
      .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt), .d_rs_use(d_rs_use), .d_rt_use(d_rt_use),
      .d_early(d_early), .d_wen(d_wen), .d_wreg(d_wreg), .d_lat(d_lat), .d_varlat(d_varlat),
      .e_flush(e_flush), .flush_all(flush_all), .ex_busy(ex_busy),
      .done_valid(done_valid), .done_reg(done_reg),
      .stallF(stallF), .stallD(stallD), .stallE(stallE), .flushE(flushE),
      .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d), .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e)
   );

   task automatic idle();
      d_valid = 0; d_rs = 0; d_rt = 0; d_rs_use = 0; d_rt_use = 0; d_early = 0;
      d_wen = 0; d_wreg = 0; d_lat = 0; d_varlat = 0; e_flush = 0; flush_all = 0;
      ex_busy = 0; done_valid = 0; done_reg = 0;
   endtask

   task automatic nxt();
      @(negedge clk);
      idle();
   endtask

   task automatic writer(input logic [5:0] r, input logic [2:0] lat);
      d_valid = 1; d_wen = 1; d_wreg = r; d_lat = lat;
   endtask

   task automatic reader(input logic [5:0] rs, input logic [5:0] rt, input logic early);
      d_valid = 1; d_rs = rs; d_rt = rt; d_rs_use = 1; d_rt_use = 1; d_early = early;
   endtask

   task automatic push_exp(input string tag, input logic sf, input logic sd, input logic se,
                           input logic fe, input logic [1:0] rsd, input logic [1:0] rtd,
                           input logic [1:0] rse, input logic [1:0] rte);
      exp_t e;
      e = '{sf: sf, sd: sd, se: se, fe: fe, rsd: rsd, rtd: rtd, rse: rse, rte: rte};
      exq.push_back(e);
      tagq.push_back(tag);
   endtask

   task automatic cmp(input string tag, input string fld, input logic [1:0] got, input logic [1:0] want);
      checks++;
      assert (got === want)
      else begin
         errors++;
         $error("FAIL %s.%s observed=%0d expected=%0d", tag, fld, got, want);
      end
   endtask

   task automatic chk();
      exp_t  e;
      string t;
      e = exq.pop_front();
      t = tagq.pop_front();
      cmp(t, "stallF",   {1'b0, stallF}, {1'b0, e.sf});
      cmp(t, "stallD",   {1'b0, stallD}, {1'b0, e.sd});
      cmp(t, "stallE",   {1'b0, stallE}, {1'b0, e.se});
      cmp(t, "flushE",   {1'b0, flushE}, {1'b0, e.fe});
      cmp(t, "fwd_rs_d", fwd_rs_d, e.rsd);
      cmp(t, "fwd_rt_d", fwd_rt_d, e.rtd);
      cmp(t, "fwd_rs_e", fwd_rs_e, e.rse);
      cmp(t, "fwd_rt_e", fwd_rt_e, e.rte);
   endtask

   initial begin
      resetn = 0;
      idle();
      #2;
      push_exp("reset", 0,0,0,0, 0,0,0,0); chk();
      @(negedge clk); resetn = 1;

      // ALU producer then dependent ALU op: no stall, forward E then M
      nxt(); writer(3, 1); d_rs = 1; d_rs_use = 1;
      push_exp("alu_prod", 0,0,0,0, 0,0,0,0); #1 chk();
      nxt(); reader(3, 2, 0); d_wen = 1; d_wreg = 6; d_lat = 1;
      push_exp("alu_dep", 0,0,0,0, FWD_E,0,0,0); #1 chk();
      nxt(); reader(3, 6, 0);
      push_exp("alu_dep2", 0,0,0,0, FWD_M,FWD_E,FWD_M,0); #1 chk();
      nxt();
      push_exp("alu_e_w", 0,0,0,0, 0,0,FWD_W,FWD_M); #1 chk();
      nxt(); reader(3, 6, 0);
      push_exp("alu_retire", 0,0,0,0, 0,FWD_W,0,0); #1 chk();
      nxt(); nxt();

      // Load then early branch: stall until the value is reachable from M
      nxt(); writer(4, 2); d_rs = 1; d_rs_use = 1;
      push_exp("lw_prod", 0,0,0,0, 0,0,0,0); #1 chk();
      nxt(); reader(4, 0, 1);
      push_exp("beq_stall", 1,1,0,1, 0,0,0,0); #1 chk();
      @(negedge clk);
      push_exp("beq_go", 0,0,0,0, FWD_M,0,0,0); #1 chk();
      nxt();
      push_exp("beq_e", 0,0,0,0, 0,0,FWD_W,0); #1 chk();

      // Load then late use: one bubble, then forward from M
      nxt(); writer(7, 2);
      push_exp("lw7_prod", 0,0,0,0, 0,0,0,0); #1 chk();
      nxt(); reader(7, 0, 0);
      push_exp("lw7_use_stall", 1,1,0,1, 0,0,0,0); #1 chk();
      @(negedge clk);
      push_exp("lw7_use_go", 0,0,0,0, FWD_M,0,0,0); #1 chk();
      nxt(); nxt(); nxt();

      // Variable-latency divide into HI, mfhi waits for done_valid
      nxt(); writer(REG_HI[5:0], 0); d_varlat = 1; d_rs = 8; d_rt = 9; d_rs_use = 1; d_rt_use = 1;
      push_exp("div_prod", 0,0,0,0, 0,0,0,0); #1 chk();
      nxt(); d_valid = 1; d_rs = REG_HI[5:0]; d_rs_use = 1; d_wen = 1; d_wreg = 10; d_lat = 1; ex_busy = 1;
      push_exp("mfhi_busy", 1,1,1,0, 0,0,0,0); #1 chk();
      @(negedge clk); done_valid = 1; done_reg = REG_HI[5:0];
      push_exp("mfhi_done", 1,1,1,0, 0,0,0,0); #1 chk();
      @(negedge clk); done_valid = 0; ex_busy = 0;
      push_exp("mfhi_go", 0,0,0,0, FWD_E,0,0,0); #1 chk();
      nxt();
      push_exp("mfhi_e", 0,0,0,0, 0,0,FWD_M,0); #1 chk();
      nxt(); nxt(); nxt();

      // Back-to-back writes of $5: newest producer wins
      nxt(); writer(5, 1);
      nxt(); writer(5, 1);
      nxt(); reader(5, 0, 0);
      push_exp("waw_e", 0,0,0,0, FWD_E,0,0,0); #1 chk();
      nxt(); reader(5, 0, 0);
      push_exp("waw_m", 0,0,0,0, FWD_M,0,FWD_M,0); #1 chk();
      nxt(); reader(5, 0, 0);
      push_exp("waw_w_busy", 0,0,0,0, FWD_W,0,FWD_W,0); #1 chk();
      nxt(); reader(5, 0, 0);
      push_exp("waw_gone", 0,0,0,0, 0,0,0,0); #1 chk();

      // D-stage squash: no allocation
      nxt(); writer(20, 1); e_flush = 1;
      nxt(); reader(20, 0, 0);
      push_exp("eflush_noalloc", 0,0,0,0, 0,0,0,0); #1 chk();

      // flush_all with producers in W, M, E
      nxt(); writer(11, 1);
      nxt(); writer(12, 1);
      nxt(); writer(13, 1);
      nxt(); reader(12, 13, 0); d_wen = 1; d_wreg = 14; d_lat = 1; flush_all = 1;
      push_exp("flush_cycle", 0,0,0,0, FWD_M,FWD_E,0,0); #1 chk();
      nxt(); reader(12, 13, 0);
      push_exp("flush_cleared", 0,0,0,0, 0,0,0,0); #1 chk();
      nxt(); reader(14, 11, 0);
      push_exp("flush_noalloc", 0,0,0,0, 0,0,0,0); #1 chk();

      // Reset asserted while stalled
      nxt(); writer(16, 1);
      nxt(); writer(15, 2); d_rs = 16; d_rs_use = 1;
      push_exp("rst_pre_fwd", 0,0,0,0, FWD_E,0,0,0); #1 chk();
      nxt(); reader(15, 0, 0); ex_busy = 1;
      push_exp("rst_pre_stall", 1,1,1,0, 0,0,FWD_M,0); #1 chk();
      #1 resetn = 0;
      #1 push_exp("rst_mid", 0,0,0,0, 0,0,0,0); chk();
      @(negedge clk); idle();
      @(negedge clk); resetn = 1;
      nxt(); reader(15, 16, 0);
      push_exp("rst_after", 0,0,0,0, 0,0,0,0); #1 chk();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
